// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup, resolution-side update and statistics bundle for the BTB.
interface branch_target_buffer_if;
  logic        lookup_valid;
  logic [31:0] pcF;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispred;

  modport master (
    output lookup_valid, pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_pc, stat_lookups, stat_hits, stat_mispred
  );

  modport slave (
    input  lookup_valid, pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_pc, stat_lookups, stat_hits, stat_mispred
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
  parameter int IDX_BITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  branch_target_buffer_if.slave bus
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_hit;
  logic [IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_up_hit;
  logic [1:0]          w_up_ctr;

  assign w_lk_idx = bus.pcF[IDX_BITS+1:2];
  assign w_lk_tag = bus.pcF[31:IDX_BITS+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign bus.pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];
  assign bus.pred_pc    = bus.pred_taken ? r_target[w_lk_idx] : (bus.pcF + 32'd4);

  assign w_up_idx = bus.upd_pc[IDX_BITS+1:2];
  assign w_up_tag = bus.upd_pc[31:IDX_BITS+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  always_comb begin
    w_up_ctr = r_ctr[w_up_idx];
    if (bus.upd_taken) begin
      if (r_ctr[w_up_idx] != 2'b11) w_up_ctr = r_ctr[w_up_idx] + 2'b01;
    end else begin
      if (r_ctr[w_up_idx] != 2'b00) w_up_ctr = r_ctr[w_up_idx] - 2'b01;
    end
  end

  // Only valid bits are reset; tag/target/ctr are qualified by valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (bus.upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_up_ctr;
        if (bus.upd_taken) r_target[w_up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.upd_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_mispred;
  logic        w_unused_bits;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_lookups <= '0;
      r_stat_hits    <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (bus.lookup_valid)                   r_stat_lookups <= r_stat_lookups + 32'd1;
      if (bus.lookup_valid && w_lk_hit)       r_stat_hits    <= r_stat_hits + 32'd1;
      if (bus.upd_valid && bus.upd_mispredict) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign bus.stat_lookups = r_stat_lookups;
  assign bus.stat_hits    = r_stat_hits;
  assign bus.stat_mispred = r_stat_mispred;
  assign w_unused_bits    = ^{bus.pcF[1:0], bus.upd_pc[1:0]};
`else
  logic w_unused_bits;

  assign bus.stat_lookups = 32'h0;
  assign bus.stat_hits    = 32'h0;
  assign bus.stat_mispred = 32'h0;
  assign w_unused_bits    = ^{bus.pcF[1:0], bus.upd_pc[1:0], bus.lookup_valid, bus.upd_mispredict};
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed plus randomized bench for branch_target_buffer against an array-based predictor model.
module tb_branch_target_buffer;
`ifdef BTB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  branch_target_buffer_if bus_if ();
  branch_target_buffer #(.IDX_BITS(4)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_if));

  int checks = 0;
  int errors = 0;

  // Reference model: 16 entries indexed by (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_lookups, m_hits, m_mispred;

  logic        last_pt;
  logic [31:0] last_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 16);
    return m_valid[i] && (m_tag[i] == int'(pc >> 6));
  endfunction

  task automatic cyc(input logic r, input logic lv, input logic [31:0] pc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utg, input logic um);
    bit          hit, exp_pt;
    logic [31:0] exp_pc;
    int          ui;
    @(negedge i_clk);
    i_rst                 = r;
    bus_if.lookup_valid   = lv;
    bus_if.pcF            = pc;
    bus_if.upd_valid      = uv;
    bus_if.upd_pc         = upc;
    bus_if.upd_taken      = ut;
    bus_if.upd_target     = utg;
    bus_if.upd_mispredict = um;
    #1;
    hit    = m_hit(pc);
    exp_pt = hit && (m_ctr[(pc >> 2) % 16] >= 2);
    exp_pc = exp_pt ? m_tgt[(pc >> 2) % 16] : pc + 32'd4;
    last_pt = bus_if.pred_taken;
    last_pc = bus_if.pred_pc;
    check("pred_taken", {31'b0, last_pt}, {31'b0, exp_pt});
    check("pred_pc", last_pc, exp_pc);
    if (r) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_lookups = 0; m_hits = 0; m_mispred = 0;
    end else begin
      m_lookups += lv;
      m_hits    += (lv && hit);
      m_mispred += (uv && um);
      if (uv) begin
        ui = int'((upc >> 2) % 16);
        if (m_hit(upc)) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1)
                         : ((m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1);
          if (ut) m_tgt[ui] = utg;
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = int'(upc >> 6);
          m_tgt[ui]   = utg;
          m_ctr[ui]   = 2;
        end
      end
    end
    @(posedge i_clk);
    #1;
    check("stat_lookups", bus_if.stat_lookups, STATS ? m_lookups : 32'h0);
    check("stat_hits",    bus_if.stat_hits,    STATS ? m_hits    : 32'h0);
    check("stat_mispred", bus_if.stat_mispred, STATS ? m_mispred : 32'h0);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd40(input logic ut, input logic [31:0] tg);
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, ut, tg, 1'b0);
  endtask

  initial begin
    logic [31:0] pc, upc;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_lookups = 0; m_hits = 0; m_mispred = 0;
    bus_if.lookup_valid = 1'b0; bus_if.pcF = '0; bus_if.upd_valid = 1'b0;
    bus_if.upd_pc = '0; bus_if.upd_taken = 1'b0; bus_if.upd_target = '0;
    bus_if.upd_mispredict = 1'b0;

    // Reset; valid bits start unknown so model checks begin after the first reset edge.
    @(negedge i_clk); i_rst = 1'b1;
    @(posedge i_clk); #1;
    cyc(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    check("t1_taken", {31'b0, last_pt}, 32'h0);
    check("t1_pc", last_pc, 32'h44);

    // Allocate 0x40 -> 0x100, then alias at 0x80.
    upd40(1'b1, 32'h100);
    look(32'h40);
    check("t2_taken", {31'b0, last_pt}, 32'h1);
    check("t2_pc", last_pc, 32'h100);
    look(32'h80);
    check("t2_alias_pc", last_pc, 32'h84);

    // Counter hysteresis; each lookup shows state before that cycle's update.
    upd40(1'b0, 32'h0);
    upd40(1'b0, 32'h0);
    check("t3_ctr1", {31'b0, last_pt}, 32'h0);
    upd40(1'b1, 32'h100);
    upd40(1'b1, 32'h100);
    check("t3_ctr1b", {31'b0, last_pt}, 32'h0);
    upd40(1'b1, 32'h100);
    check("t3_ctr2", {31'b0, last_pt}, 32'h1);
    upd40(1'b1, 32'h100);
    upd40(1'b1, 32'h100);
    upd40(1'b1, 32'h100);
    upd40(1'b0, 32'h0);
    look(32'h40);
    check("t3_sat", {31'b0, last_pt}, 32'h1);

    // Same-cycle update and lookup: no bypass.
    upd40(1'b1, 32'h200);
    check("t4_old", last_pc, 32'h100);
    cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
    check("t4_new", last_pc, 32'h200);
    look(32'h1000);
    check("t4_nt_miss", last_pc, 32'h1004);

    // Reset concurrent with an update discards it.
    cyc(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1);
    look(32'h40);
    check("t5_40", last_pc, 32'h44);
    look(32'h80);
    check("t5_80", last_pc, 32'h84);
    look(32'hFFFF_FFFC);
    check("t5_wrap", last_pc, 32'h0);

    // Statistics: 10 lookups, 4 hits, 3 mispredicts.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, (i < 4) ? 32'h40 : 32'h80, (i % 3 == 0) && (i < 9), 32'h1000, 1'b0, 32'h0, 1'b1);
    check("t6_lookups", bus_if.stat_lookups, STATS ? 32'd10 : 32'd0);
    check("t6_hits",    bus_if.stat_hits,    STATS ? 32'd4  : 32'd0);
    check("t6_mispred", bus_if.stat_mispred, STATS ? 32'd3  : 32'd0);

    // Random traffic over a small PC pool so hits, aliasing and saturation all occur.
    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      cyc($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)), pc,
          1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 2) != 0),
          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
